axi4l_mailbox: RTL and testbench
================================

Name: axi4l_mailbox

Overview:
AXI4-lite slave that terminates the 8-byte submap window driven by the upstream decoder's subm_* master port (address bit [2:2]). It contains two FIFOs. The TX FIFO is filled by CPU writes and drained by a hardware stream. The RX FIFO is filled by a hardware stream and drained by CPU reads. Word 1 is a status/control register.

Parameters:
DEPTH_LOG2, 4, log2 of entries per FIFO (depth 16); legal range 1..7.

Ports:
aclk  in  1  clock
areset_n  in  1  reset
awvalid  in  1  AW valid
awready  out  1  AW ready
awaddr  in  [2:2]  write word select
awprot  in  3  ignored
wvalid  in  1  W valid
wready  out  1  W ready
wdata  in  32  write data
wstrb  in  4  byte strobes
bvalid  out  1  B valid
bready  in  1  B ready
bresp  out  2  write response
arvalid  in  1  AR valid
arready  out  1  AR ready
araddr  in  [2:2]  read word select
arprot  in  3  ignored
rvalid  out  1  R valid
rready  in  1  R ready
rdata  out  32  read data
rresp  out  2  read response
tx_valid_o  out  1  TX stream head valid
tx_ready_i  in  1  TX stream consumer ready
tx_data_o  out  32  TX FIFO head
rx_valid_i  in  1  RX stream producer valid
rx_ready_o  out  1  RX FIFO not full
rx_data_i  in  32  RX stream data

Behaviour:
- Clock and reset: one clock, aclk. Reset areset_n is asynchronous, active-low; asserting it mid-transaction aborts everything.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=00, rvalid=0, rdata=0, rresp=00, tx_valid_o=0, rx_ready_o=1. Both FIFOs empty, pointers and counts 0.
- FIFO memories are not reset. tx_data_o is don't-care while tx_valid_o=0.
- AW and W channels:
  - Each channel is captured independently into a holding register. awready = !aw_held; wready = !w_held.
  - Write executes in the first cycle where aw_held & w_held & !bvalid.
  - bvalid is asserted the next cycle and held until bready.
  - On the B handshake, aw_held and w_held clear.
- Simultaneous AW+W accept: bvalid is asserted 2 cycles after the handshake cycle.
- Write to word 0 (data):
  - wstrb==0000: no push, OKAY.
  - Otherwise push full wdata (partial strobes still push all 32 bits) if TX is not full, OKAY.
  - If TX is full: data is dropped, bresp=10 (SLVERR).
- Write to word 1 (control), applied only when the corresponding strobe is set:
  - wdata[0]=1 flushes TX.
  - wdata[1]=1 flushes RX.
  - Bresp is always OKAY.
- AR and R channels:
  - arready = !ar_held & !rvalid.
  - The cycle after AR acceptance: rvalid=1, with rdata and rresp registered.
  - rvalid is held with rdata stable until rready. The R handshake clears rvalid and ar_held.
- Read of word 0:
  - RX not empty: rdata = RX head, pop one entry, OKAY.
  - RX empty: rdata=0, no pop, rresp=10.
- Read of word 1:
  - [7:0] tx_count; [15:8] rx_count.
  - [16] tx_full, [17] tx_empty, [18] rx_full, [19] rx_empty.
  - Other bits 0. Always OKAY, no side effects.
  - The status value is sampled in the cycle the read executes.
- TX stream:
  - tx_valid_o = (tx_count != 0), tx_data_o = memory[tx_rd_ptr].
  - Pop on tx_valid_o & tx_ready_i.
  - A pushed word is visible on tx_valid_o the cycle after the push.
- RX stream:
  - rx_ready_o = !rx_full; push on rx_valid_i & rx_ready_o.
  - A pushed word is readable by a read executing the next cycle or later.
- Counts:
  - Width DEPTH_LOG2+1. Full when count == 2**DEPTH_LOG2.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Simultaneous events:
  - Push and pop in the same cycle: both occur if individually legal; count unchanged.
  - The full/empty check uses the pre-cycle count. A push to a full FIFO is rejected even with a simultaneous pop; a pop from an empty FIFO is ignored even with a simultaneous push.
  - Flush beats a same-cycle push or pop on that FIFO: pointers and count go to 0, and the pushed word is discarded.
- Write and read are independent. A same-cycle CPU push on TX and CPU pop on RX are both allowed.

Test Plan:
1. Reset → check values: awready=wready=arready=1, bvalid=rvalid=0, tx_valid_o=0, rx_ready_o=1. Read word 1 → rdata=0x000A0000.
2. Write 0xDEADBEEF to word 0 with tx_ready_i=0 → bresp=00. Next cycle tx_valid_o=1, tx_data_o=0xDEADBEEF. Raise tx_ready_i → tx_valid_o=0 the cycle after.
3. Write 17 words to word 0 with tx_ready_i=0 → first 16 get OKAY, 17th gets bresp=10. Status reads tx_count=16, tx_full=1 (rdata=0x00090010).
4. Push 0x11, 0x22 on the RX stream, then read word 0 three times → 0x11 OKAY, 0x22 OKAY, then 0 with rresp=10. rx_ready_o stays 1 throughout.
5. W before AW by 3 cycles, with bready held low 4 cycles → bvalid is asserted the cycle after both channels are held and stays stable. awready and wready stay 0 until the B handshake.
6. Fill RX to 16, then write 0x2 to word 1 while rx_valid_i=1 → rx_count=0, rx_ready_o=1 next cycle. Status reads rx_empty=1; the concurrent word is not stored.

Source files
------------

// File: rtl/axi4l_mailbox.sv
// AXI4-lite mailbox on a two-word window: word 0 pushes TX / pops RX, word 1 is status/control.
// TX FIFO is drained by a hardware stream; RX FIFO is filled by one.
module axi4l_mailbox #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [2:2]  awaddr,
  input  logic [2:0]  awprot,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:2]  araddr,
  input  logic [2:0]  arprot,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] tx_data_o,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [31:0] rx_data_i
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned PW = DEPTH_LOG2;
  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FullCnt = CW'(Depth);

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic          aw_addr_q, aw_addr_d;
  logic [31:0]   w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [31:0]   tx_mem_q [Depth];
  logic [31:0]   rx_mem_q [Depth];

  logic aw_hs, w_hs, b_hs, r_hs, wr_exec, rd_exec;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic [31:0] status;
  logic unused_prot;

  assign unused_prot = ^{awprot, arprot};

  assign awready = !aw_held_q;
  assign wready  = !w_held_q;
  assign arready = !ar_held_q && !rvalid_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign b_hs    = bvalid_q && bready;
  assign r_hs    = rvalid_q && rready;
  assign wr_exec = aw_held_q && w_held_q && !bvalid_q;
  assign rd_exec = arvalid && arready;

  assign tx_full  = (tx_cnt_q == FullCnt);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FullCnt);
  assign rx_empty = (rx_cnt_q == '0);

  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_mem_q[tx_rd_q];
  assign rx_ready_o = !rx_full;

  // Control bits live in byte 0, so only wstrb[0] gates them.
  assign tx_flush = wr_exec && aw_addr_q && w_strb_q[0] && w_data_q[0];
  assign rx_flush = wr_exec && aw_addr_q && w_strb_q[0] && w_data_q[1];
  assign tx_push  = wr_exec && !aw_addr_q && (w_strb_q != 4'h0) && !tx_full;
  assign tx_pop   = tx_valid_o && tx_ready_i;
  assign rx_push  = rx_valid_i && !rx_full && !rx_flush;
  assign rx_pop   = rd_exec && !araddr[2] && !rx_empty;

  assign status = {12'd0, rx_empty, rx_full, tx_empty, tx_full, 8'(rx_cnt_q), 8'(tx_cnt_q)};

  always_comb begin
    aw_held_d = b_hs ? 1'b0 : (aw_hs ? 1'b1 : aw_held_q);
    w_held_d  = b_hs ? 1'b0 : (w_hs ? 1'b1 : w_held_q);
    ar_held_d = r_hs ? 1'b0 : (rd_exec ? 1'b1 : ar_held_q);
    aw_addr_d = aw_hs ? awaddr[2] : aw_addr_q;
    w_data_d  = w_hs ? wdata : w_data_q;
    w_strb_d  = w_hs ? wstrb : w_strb_q;

    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (b_hs) begin
      bvalid_d = 1'b0;
    end else if (wr_exec) begin
      bvalid_d = 1'b1;
      bresp_d  = (!aw_addr_q && (w_strb_q != 4'h0) && tx_full) ? 2'b10 : 2'b00;
    end

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rd_exec) begin
      rvalid_d = 1'b1;
      if (araddr[2]) begin
        rdata_d = status;
        rresp_d = 2'b00;
      end else begin
        rdata_d = rx_empty ? 32'd0 : rx_mem_q[rx_rd_q];
        rresp_d = rx_empty ? 2'b10 : 2'b00;
      end
    end else if (r_hs) begin
      rvalid_d = 1'b0;
    end
  end

  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
      if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
      else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    end
  end

  always_comb begin
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
      if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
      else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      ar_held_q <= 1'b0;
      aw_addr_q <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      ar_held_q <= ar_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage is deliberately left unreset; count/pointers define validity.
  always_ff @(posedge aclk) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= w_data_q;
    if (rx_push) rx_mem_q[rx_wr_q] <= rx_data_i;
  end

endmodule

// File: tb/tb_axi4l_mailbox.sv
// Directed bench for axi4l_mailbox: stimulus queues expected B/R responses, a negedge monitor
// pops and compares them on each handshake; stream and ready signals are checked inline.
module tb_axi4l_mailbox;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:2]  awaddr = 1'b0, araddr = 1'b0;
  logic [2:0]  awprot = 3'd0, arprot = 3'd0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        tx_valid_o, tx_ready_i = 1'b0, rx_valid_i = 1'b0, rx_ready_o;
  logic [31:0] tx_data_o, rx_data_i = '0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int n_cmp = 0;
  int n_err = 0;

  axi4l_mailbox #(.DEPTH_LOG2(4)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected event, expected handshake at %0t", name, $time);
  endtask

  // Scoreboard monitor: compares each B/R handshake against the oldest queued expectation.
  always @(negedge aclk) begin
    if (areset_n) begin
      if (bvalid && bready) begin
        if (exp_b.size() == 0) fail("b_unexpected");
        else check("bresp", 32'(bresp), 32'(exp_b.pop_front()));
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) fail("r_unexpected");
        else begin
          rexp_t e;
          e = exp_r.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
        end
      end
    end
  end

  task automatic axi_write(input logic addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    exp_b.push_back(exp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge aclk);
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      @(posedge aclk); #1;
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      cyc++;
    end
    cyc = 0;
    while (!bvalid && cyc < 50) begin
      @(posedge aclk); #1;
      cyc++;
    end
    if (cyc >= 50) fail("b_timeout");
    @(posedge aclk); #1;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic addr, input logic [31:0] data, input logic [1:0] resp);
    rexp_t e;
    int cyc = 0;
    e.data = data; e.resp = resp;
    exp_r.push_back(e);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    @(negedge aclk);
    while (!arready && cyc < 50) begin
      @(negedge aclk);
      cyc++;
    end
    if (cyc >= 50) fail("ar_timeout");
    @(posedge aclk); #1;
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 50) begin
      @(posedge aclk); #1;
      cyc++;
    end
    if (cyc >= 50) fail("r_timeout");
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;

    // 1: reset state
    @(negedge aclk);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    @(posedge aclk); #1;
    axi_read(1'b1, 32'h000A_0000, 2'b00);

    // 2: zero-strobe write is a no-op; single push then stream drain
    axi_write(1'b0, 32'h1234_5678, 4'h0, 2'b00);
    @(negedge aclk);
    check("nostrb_tx_valid", 32'(tx_valid_o), 32'd0);
    @(posedge aclk); #1;
    axi_write(1'b0, 32'hDEAD_BEEF, 4'hF, 2'b00);
    @(negedge aclk);
    check("push_tx_valid", 32'(tx_valid_o), 32'd1);
    check("push_tx_data", tx_data_o, 32'hDEAD_BEEF);
    @(posedge aclk); #1;
    tx_ready_i = 1'b1;
    @(posedge aclk); #1;
    tx_ready_i = 1'b0;
    @(negedge aclk);
    check("drain_tx_valid", 32'(tx_valid_o), 32'd0);
    @(posedge aclk); #1;

    // 3: fill TX, overflow gives SLVERR, strobe-less control write ignored, flush
    for (int i = 0; i < 17; i++)
      axi_write(1'b0, 32'h100 + 32'(i), 4'hF, (i < 16) ? 2'b00 : 2'b10);
    axi_read(1'b1, 32'h0009_0010, 2'b00);
    axi_write(1'b1, 32'h1, 4'h0, 2'b00);
    axi_read(1'b1, 32'h0009_0010, 2'b00);
    @(negedge aclk);
    check("full_tx_head", tx_data_o, 32'h100);
    @(posedge aclk); #1;
    axi_write(1'b1, 32'h1, 4'h1, 2'b00);
    @(negedge aclk);
    check("flush_tx_valid", 32'(tx_valid_o), 32'd0);
    @(posedge aclk); #1;
    axi_read(1'b1, 32'h000A_0000, 2'b00);

    // 4: RX stream push, CPU pops, underflow gives SLVERR
    rx_valid_i = 1'b1; rx_data_i = 32'h11;
    @(negedge aclk);
    check("rx_ready_p1", 32'(rx_ready_o), 32'd1);
    @(posedge aclk); #1;
    rx_data_i = 32'h22;
    @(negedge aclk);
    check("rx_ready_p2", 32'(rx_ready_o), 32'd1);
    @(posedge aclk); #1;
    rx_valid_i = 1'b0;
    axi_read(1'b0, 32'h11, 2'b00);
    axi_read(1'b0, 32'h22, 2'b00);
    axi_read(1'b0, 32'h0, 2'b10);
    @(negedge aclk);
    check("rx_ready_after", 32'(rx_ready_o), 32'd1);
    @(posedge aclk); #1;

    // 5: W leads AW by 3 cycles, B back-pressured for 4 cycles
    awaddr = 1'b0; wdata = 32'hCAFE_0005; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(posedge aclk); #1;
    wvalid = 1'b0;
    @(negedge aclk);
    check("wlead_wready", 32'(wready), 32'd0);
    check("wlead_awready", 32'(awready), 32'd1);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    @(negedge aclk);
    check("exec_bvalid", 32'(bvalid), 32'd0);
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("hold_bvalid", 32'(bvalid), 32'd1);
      check("hold_bresp", 32'(bresp), 32'd0);
      check("hold_awready", 32'(awready), 32'd0);
      check("hold_wready", 32'(wready), 32'd0);
      @(posedge aclk); #1;
    end
    exp_b.push_back(2'b00);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    @(negedge aclk);
    check("post_b_awready", 32'(awready), 32'd1);
    check("post_b_wready", 32'(wready), 32'd1);
    check("post_b_bvalid", 32'(bvalid), 32'd0);
    check("wlead_tx_data", tx_data_o, 32'hCAFE_0005);
    @(posedge aclk); #1;
    tx_ready_i = 1'b1;
    @(posedge aclk); #1;
    tx_ready_i = 1'b0;

    // 6: fill RX, flush while stream keeps offering a word
    for (int i = 0; i < 16; i++) begin
      rx_valid_i = 1'b1; rx_data_i = 32'h200 + 32'(i);
      @(posedge aclk); #1;
    end
    rx_valid_i = 1'b0;
    @(negedge aclk);
    check("rx_full_ready", 32'(rx_ready_o), 32'd0);
    @(posedge aclk); #1;
    axi_read(1'b1, 32'h0006_1000, 2'b00);
    exp_b.push_back(2'b00);
    rx_valid_i = 1'b1; rx_data_i = 32'hBAD0_BAD0;
    awaddr = 1'b1; wdata = 32'h2; wstrb = 4'h1;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge aclk); #1;
    rx_valid_i = 1'b0;
    @(negedge aclk);
    check("flush_rx_ready", 32'(rx_ready_o), 32'd1);
    check("flush_bvalid", 32'(bvalid), 32'd1);
    @(posedge aclk); #1;
    bready = 1'b0;
    axi_read(1'b1, 32'h000A_0000, 2'b00);
    axi_read(1'b0, 32'h0, 2'b10);

    repeat (3) @(posedge aclk);
    check("b_queue_drained", 32'(exp_b.size()), 32'd0);
    check("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
